// File: rtl/zipwith_combine_pkg.sv
// Shared definitions for the zipwith_combine block: operation encodings and constants.
package zipwith_combine_pkg;

    typedef enum logic [1:0] {
        MODE_ADD     = 2'd0,
        MODE_SUB     = 2'd1,
        MODE_ABSDIFF = 2'd2,
        MODE_MAX     = 2'd3
    } mode_e;

    // Every result token carries a count of one.
    localparam logic [15:0] COUNT_ONE = 16'h1;

endpackage

// File: rtl/zipwith_combine_fifo.sv
// DEPTH x WIDTH result FIFO with occupancy output; flush empties it synchronously.
module zipwith_combine_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [4:0]       level,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [4:0] DepthL = 5'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [4:0]       count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == 5'd0);
    assign level   = count;
    assign do_wr   = wr_en & (count < DepthL);
    assign do_rd   = rd_en & ~empty;
    // Head is forced to zero when empty so the output is clean in and after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array; no reset needed since reads are masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; power-of-two depth makes pointer wrap implicit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            count <= count + 5'(do_wr) - 5'(do_rd);
        end
    end

endmodule

// File: rtl/zipwith_combine.sv
// Pairs one token from each input stream, combines them per MODE, and queues the result.
module zipwith_combine
    import zipwith_combine_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter bit          SAT   = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] In1_DATA,
    input  logic [15:0]      In1_COUNT,
    input  logic             In1_SEND,
    output logic             In1_ACK,
    input  logic [WIDTH-1:0] In2_DATA,
    input  logic [15:0]      In2_COUNT,
    input  logic             In2_SEND,
    output logic             In2_ACK,
    input  logic [1:0]       MODE,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] Out1_DATA,
    output logic [15:0]      Out1_COUNT,
    output logic             Out1_SEND,
    input  logic             Out1_RDY,
    input  logic             Out1_ACK,
    output logic [4:0]       LEVEL
);

    localparam logic [5:0] DepthCap = 6'(DEPTH);

    logic             consume;
    logic             stage_valid;
    logic [WIDTH-1:0] stage_data;
    logic [WIDTH-1:0] result;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [4:0]       level;
    logic             fifo_empty;
    logic             unused_inputs;

    assign unused_inputs = ^{In1_COUNT, In2_COUNT, Out1_ACK};

    // Consume only when both operands are present and the stage token is guaranteed a slot.
    assign consume = In1_SEND & In2_SEND & ~FLUSH & ~RESET
                   & (({1'b0, level} + {5'b0, stage_valid}) < DepthCap);

    assign In1_ACK    = consume;
    assign In2_ACK    = consume;
    assign Out1_SEND  = ~fifo_empty & Out1_RDY & ~FLUSH;
    assign Out1_COUNT = COUNT_ONE;
    assign LEVEL      = level;

    // Operation select; the extra MSB of sum/diff is the carry/borrow.
    always_comb begin
        sum  = {1'b0, In1_DATA} + {1'b0, In2_DATA};
        diff = {1'b0, In1_DATA} - {1'b0, In2_DATA};
        result = sum[WIDTH-1:0];
        case (mode_e'(MODE))
            MODE_ADD:     result = (SAT && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
            MODE_SUB:     result = (SAT && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
            MODE_ABSDIFF: result = diff[WIDTH] ? (In2_DATA - In1_DATA) : diff[WIDTH-1:0];
            MODE_MAX:     result = diff[WIDTH] ? In2_DATA : In1_DATA;
            default:      result = sum[WIDTH-1:0];
        endcase
    end

    // Single result stage between the consume cycle and the FIFO write.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (FLUSH) begin
            stage_valid <= 1'b0;
        end else begin
            stage_valid <= consume;
            if (consume) begin
                stage_data <= result;
            end
        end
    end

    zipwith_combine_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .reset   (RESET),
        .flush   (FLUSH),
        .wr_en   (stage_valid),
        .wr_data (stage_data),
        .rd_en   (Out1_SEND),
        .rd_data (Out1_DATA),
        .level   (level),
        .empty   (fifo_empty)
    );

endmodule
